// File: rtl/frame_disassembly.sv
// rtl/frame_disassembly.sv - biphase-mark frame receiver: sync/parity check, payload bytes to audio FIFO
//
// Optional feature macro: FRAME_STATS_EN (adds good_count / bad_count outputs).
//
// Ports:
//   clk_in        system clock
//   rst_n_in      asynchronous active-low reset (assert async, release synchronised)
//   line_in       raw optical receiver output, asynchronous to clk_in
//   fifo_full_in  downstream FIFO full
//   dout          payload byte
//   dout_valid    one-cycle write strobe per byte
//   frame_done    one-cycle pulse after the last byte of a good frame
//   frame_err     one-cycle pulse on sync/timing/parity error
//   overflow      sticky, a byte was dropped because the FIFO was full
//   locked        high between a valid sync and the next error/idle
//   good_count    (FRAME_STATS_EN) wrapping count of frame_done pulses
//   bad_count     (FRAME_STATS_EN) wrapping count of frame_err pulses
module frame_disassembly #(
    parameter int BIT_CYCLES  = 16,
    parameter int FRAME_BYTES = 4,
    parameter int IDLE_BITS   = 3
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        line_in,
    input  logic        fifo_full_in,
    output logic [7:0]  dout,
    output logic        dout_valid,
    output logic        frame_done,
    output logic        frame_err,
    output logic        overflow,
    output logic        locked
`ifdef FRAME_STATS_EN
    ,
    output logic [15:0] good_count,
    output logic [15:0] bad_count
`endif
);

    localparam int SAT   = IDLE_BITS * BIT_CYCLES;
    localparam int CW    = $clog2(SAT + 1);
    localparam int DW    = 8 * FRAME_BYTES;
    localparam int NBITS = DW + 1;
    localparam int BW    = $clog2(NBITS + 1);
    localparam int IW    = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;

    localparam logic [CW-1:0] T_SHORT  = CW'(BIT_CYCLES / 4);
    localparam logic [CW-1:0] T_LONG   = CW'((3 * BIT_CYCLES) / 4);
    localparam logic [CW-1:0] T_SYNC   = CW'((5 * BIT_CYCLES) / 4);
    localparam logic [CW-1:0] T_BAD    = CW'((7 * BIT_CYCLES) / 4);
    localparam logic [CW-1:0] CNT_MAX  = CW'(SAT);
    localparam logic [CW-1:0] CNT_PRE  = CW'(SAT - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(NBITS - 1);
    localparam logic [IW-1:0] LAST_BYTE = IW'(FRAME_BYTES - 1);

    typedef enum logic [1:0] {HUNT, DATA, CHECK, EMIT} state_t;
    typedef enum logic [1:0] {C_SHORT, C_LONG, C_SYNC, C_BAD} cls_t;

    state_t          state, state_nxt;
    cls_t            cls;
    logic            rst_meta, rst_sync;
    logic            s1, s2, s3;
    logic            edge_det, sat_hit;
    logic [CW-1:0]   cnt;
    logic [BW-1:0]   bit_cnt;
    logic [DW-1:0]   shreg;
    logic            par_acc;
    logic            half;
    logic [7:0]      out_buf [FRAME_BYTES];
    logic [IW-1:0]   byte_idx;

    logic            locked_nxt, err_nxt, done_nxt;
    logic            frame_clr, half_set, bit_push, bit_val, buf_load, drop;

    // Reset release is re-timed to clk_in; assertion still clears everything at once.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rst_meta <= 1'b0;
            rst_sync <= 1'b0;
        end else begin
            rst_meta <= 1'b1;
            rst_sync <= rst_meta;
        end
    end

    // Two-flop synchroniser plus one delay flop for edge detection.
    always_ff @(posedge clk_in or negedge rst_sync) begin
        if (!rst_sync) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= line_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign edge_det = s2 ^ s3;
    // One-shot: fires only on the step into saturation, not while parked there.
    assign sat_hit  = !edge_det && (cnt == CNT_PRE);

    always_ff @(posedge clk_in or negedge rst_sync) begin
        if (!rst_sync) begin
            cnt <= '0;
        end else if (edge_det) begin
            cnt <= '0;
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CW'(1);
        end
    end

    always_comb begin
        cls = C_BAD;
        if (cnt >= T_SHORT && cnt < T_LONG) begin
            cls = C_SHORT;
        end else if (cnt >= T_LONG && cnt < T_SYNC) begin
            cls = C_LONG;
        end else if (cnt >= T_SYNC && cnt < T_BAD) begin
            cls = C_SYNC;
        end
    end

    always_ff @(posedge clk_in or negedge rst_sync) begin
        if (!rst_sync) begin
            state <= HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        locked_nxt = locked;
        err_nxt    = 1'b0;
        done_nxt   = 1'b0;
        frame_clr  = 1'b0;
        half_set   = 1'b0;
        bit_push   = 1'b0;
        bit_val    = 1'b0;
        buf_load   = 1'b0;
        drop       = 1'b0;
        dout_valid = 1'b0;
        dout       = 8'h00;
        case (state)
            HUNT: begin
                if (edge_det && cls == C_SYNC) begin
                    state_nxt  = DATA;
                    frame_clr  = 1'b1;
                    locked_nxt = 1'b1;
                end
            end
            DATA: begin
                if (sat_hit) begin
                    err_nxt    = 1'b1;
                    locked_nxt = 1'b0;
                    state_nxt  = HUNT;
                end else if (edge_det) begin
                    if (cls == C_SYNC) begin
                        // Abandon the partial frame but resync on this marker.
                        err_nxt   = 1'b1;
                        frame_clr = 1'b1;
                    end else if (cls == C_BAD || (half && cls != C_SHORT)) begin
                        err_nxt    = 1'b1;
                        locked_nxt = 1'b0;
                        state_nxt  = HUNT;
                    end else if (cls == C_LONG) begin
                        bit_push = 1'b1;
                        bit_val  = 1'b0;
                    end else if (half) begin
                        bit_push = 1'b1;
                        bit_val  = 1'b1;
                    end else begin
                        half_set = 1'b1;
                    end
                    if (bit_push && bit_cnt == LAST_BIT) begin
                        state_nxt = CHECK;
                    end
                end
            end
            CHECK: begin
                if (par_acc) begin
                    err_nxt   = 1'b1;
                    state_nxt = HUNT;
                end else begin
                    buf_load  = 1'b1;
                    state_nxt = EMIT;
                end
            end
            EMIT: begin
                dout = out_buf[byte_idx];
                if (fifo_full_in) begin
                    drop = 1'b1;
                end else begin
                    dout_valid = 1'b1;
                end
                if (byte_idx == LAST_BYTE) begin
                    done_nxt  = 1'b1;
                    state_nxt = HUNT;
                end
            end
            default: state_nxt = HUNT;
        endcase
        // Idle line outside DATA: just drop lock (DATA handled above with an error).
        if (sat_hit && state != DATA) begin
            locked_nxt = 1'b0;
            state_nxt  = HUNT;
        end
    end

    always_ff @(posedge clk_in or negedge rst_sync) begin
        if (!rst_sync) begin
            locked     <= 1'b0;
            frame_err  <= 1'b0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
            bit_cnt    <= '0;
            shreg      <= '0;
            par_acc    <= 1'b0;
            half       <= 1'b0;
            byte_idx   <= '0;
            for (int i = 0; i < FRAME_BYTES; i++) begin
                out_buf[i] <= 8'h00;
            end
        end else begin
            locked     <= locked_nxt;
            frame_err  <= err_nxt;
            frame_done <= done_nxt;
            if (drop) begin
                overflow <= 1'b1;
            end
            if (frame_clr) begin
                bit_cnt <= '0;
                par_acc <= 1'b0;
                half    <= 1'b0;
            end else if (bit_push) begin
                // The final bit is parity only; it feeds the accumulator, not the payload.
                if (bit_cnt != LAST_BIT) begin
                    shreg <= {shreg[DW-2:0], bit_val};
                end
                par_acc <= par_acc ^ bit_val;
                bit_cnt <= bit_cnt + BW'(1);
                half    <= 1'b0;
            end else if (half_set) begin
                half <= 1'b1;
            end
            if (buf_load) begin
                for (int i = 0; i < FRAME_BYTES; i++) begin
                    out_buf[i] <= shreg[8*(FRAME_BYTES-1-i) +: 8];
                end
                byte_idx <= '0;
            end else if (state == EMIT) begin
                byte_idx <= byte_idx + IW'(1);
            end
        end
    end

`ifdef FRAME_STATS_EN
    always_ff @(posedge clk_in or negedge rst_sync) begin
        if (!rst_sync) begin
            good_count <= 16'h0000;
            bad_count  <= 16'h0000;
        end else begin
            if (frame_done) begin
                good_count <= good_count + 16'h0001;
            end
            if (frame_err) begin
                bad_count <= bad_count + 16'h0001;
            end
        end
    end
`endif

endmodule

// File: doc/frame_disassembly.md
Name: frame_disassembly

Overview:
- Receive-side counterpart of frame_assembly; lives on the receiving FPGA behind the optical photodiode input.
- Recovers biphase-mark-coded frames from the asynchronous serial line.
- Checks frame sync and parity, then pushes the 4 payload bytes of each good frame into the downstream audio FIFO, one byte per cycle.
- Reports framing/parity errors and FIFO overflow.

Parameters:
- BIT_CYCLES, 16, clk_in cycles per data-bit period (even, >=8).
- FRAME_BYTES, 4, payload bytes per frame.
- IDLE_BITS, 3, bit periods without an edge before the line is declared idle.

Ports:
- clk_in  input  1  system clock
- rst_n_in  input  1  asynchronous active-low reset
- line_in  input  1  raw optical receiver output, asynchronous to clk_in
- fifo_full_in  input  1  downstream FIFO full
- dout  output  8  payload byte
- dout_valid  output  1  dout valid, one-cycle strobe per byte (FIFO wr_en)
- frame_done  output  1  one-cycle pulse after the last byte of a good frame is presented
- frame_err  output  1  one-cycle pulse on sync/timing/parity error
- overflow  output  1  sticky; set when a byte is dropped due to fifo_full_in
- locked  output  1  high between first valid sync and next error/idle

Behaviour:
- Reset: all outputs 0; state HUNT; counters and shift register cleared. Assertion is asynchronous, deassertion is taken synchronously.
- Input conditioning: line_in passes through a 2-flop synchronizer plus one delay flop. An edge is any change between the last two samples.
- Interval counter: clears on each edge and saturates at IDLE_BITS*BIT_CYCLES. At each edge the elapsed count c is classified (B = BIT_CYCLES):
  - SHORT: B/4 <= c < 3B/4
  - LONG: 3B/4 <= c < 5B/4
  - SYNC: 5B/4 <= c < 7B/4
  - BAD: anything else
- Decoding: LONG gives bit 0. SHORT followed by SHORT gives bit 1. SHORT followed by anything other than SHORT is an error.
- Frame format: SYNC interval, then FRAME_BYTES*8 data bits MSB first (byte 0 first), then 1 even-parity bit covering the data bits.
- HUNT: ignore everything until a SYNC interval, then go to DATA. Clear the bit count and parity accumulator; locked=1.
- DATA: shift decoded bits in.
  - After 8*FRAME_BYTES+1 bits, go to CHECK.
  - BAD, broken SHORT pair, or SYNC mid-frame: pulse frame_err, locked=0, go to HUNT. A mid-frame SYNC is still treated as the start of a new frame: go to DATA instead of HUNT and keep locked=1.
- CHECK (1 cycle):
  - Parity odd: frame_err pulse, go to HUNT, nothing emitted, locked stays 1.
  - Parity even: latch payload into the output buffer, go to EMIT.
- EMIT: present bytes 0..FRAME_BYTES-1 on consecutive cycles with dout_valid=1.
  - If fifo_full_in=1 in a byte's cycle, drop that byte: dout_valid=0, overflow<=1. Emission does not stall.
  - After the last byte: frame_done pulse, go to HUNT.
  - EMIT takes FRAME_BYTES cycles, far shorter than one bit period, so the next SYNC is never missed. Edges during CHECK/EMIT are still timed by the interval counter.
- Idle: counter saturation in any state sets locked=0 and returns to HUNT. Saturation in DATA also pulses frame_err.
- Latency: first dout_valid is 2 cycles after the edge that completes the parity bit (CHECK cycle, then EMIT), plus 2 synchronizer cycles.
- overflow clears only on reset.

Optional Feature:
- FRAME_STATS_EN. Defined: adds output ports good_count[15:0] and bad_count[15:0].
  - good_count increments on frame_done; bad_count increments on frame_err.
  - Both wrap at 16'hFFFF -> 0 and reset to 0.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- BIT_CYCLES=16; send SYNC plus payload A5,3C,00,FF with parity 0 -> dout_valid on 4 consecutive cycles with A5,3C,00,FF; one frame_done; frame_err=0; locked=1.
- Same frame with parity bit flipped to 1 -> no dout_valid; one frame_err; locked stays 1; next correct frame (01,02,03,04) is emitted normally.
- Hold fifo_full_in=1 for the cycle of byte 2 of frame 11,22,33,44 -> dout_valid only for 11,22,44; overflow=1 and stays set through later frames until rst_n_in=0.
- Insert a 40-cycle gap (BAD) after 10 data bits -> frame_err pulse; locked=0; no bytes; recovery on the next SYNC.
- Line stuck low for 48+ cycles after a good frame -> locked falls to 0 with no frame_err; SYNC-only jitter of +/-3 cycles on every interval still decodes frames correctly.
- Assert rst_n_in mid-DATA -> all outputs 0 immediately (asynchronously); after release no output until a fresh SYNC; with FRAME_STATS_EN, counts read 0.
